// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the vending controller.
// Combinational only. No latency.
// No backpressure: these are types and pure functions.
package vend_pkg;

  // One-hot coin encodings as seen from the coin acceptor
  localparam logic [4:0] COIN_NONE        = 5'b00000;
  localparam logic [4:0] COIN_QUARTER     = 5'b00001;
  localparam logic [4:0] COIN_FIFTY       = 5'b00010;
  localparam logic [4:0] COIN_SEVENTYFIVE = 5'b00100;
  localparam logic [4:0] COIN_DOLLAR      = 5'b01000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } vend_state_t;

  // Coin value in quarters plus a flag saying the encoding is one we accept
  typedef struct packed {
    logic       legal;
    logic [2:0] value;
  } coin_val_t;

  // Multi-hot patterns and the reserved bit decode as illegal with value 0
  function automatic coin_val_t coin_value(input logic [4:0] c);
    coin_val_t r;
    r.legal = 1'b1;
    r.value = 3'd0;
    case (c)
      COIN_NONE:        r.value = 3'd0;
      COIN_QUARTER:     r.value = 3'd1;
      COIN_FIFTY:       r.value = 3'd2;
      COIN_SEVENTYFIVE: r.value = 3'd3;
      COIN_DOLLAR:      r.value = 3'd4;
      default:          r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vend_inventory.sv
// Per-slot item counters with decrement on vend and refill on restock.
// Counts update one cycle after dec/restock; empty is decoded from the registers.
// No backpressure: decrement of an empty slot is ignored, restock always wins.
module vend_inventory
  import vend_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int INV_MAX   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [SLOT_W-1:0]    dec_id,
  input  logic                 restock_valid,
  input  logic [SLOT_W-1:0]    restock_id,
  output logic [NUM_SLOTS-1:0] empty
);

  localparam int CNT_W = $clog2(INV_MAX + 1);

  logic [CNT_W-1:0] count_q [NUM_SLOTS];

  // Counter update: restock overrides a same-cycle decrement of that slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) count_q[i] <= CNT_W'(INV_MAX);
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (restock_valid && restock_id == SLOT_W'(i))
          count_q[i] <= CNT_W'(INV_MAX);
        else if (dec_valid && dec_id == SLOT_W'(i) && count_q[i] != '0)
          count_q[i] <= count_q[i] - 1'b1;
      end
    end
  end

  // Empty flags straight from the counter registers
  always_comb begin
    empty = '0;
    for (int i = 0; i < NUM_SLOTS; i++) empty[i] = (count_q[i] == '0);
  end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, selection vs inventory, dispenser handshake, change return.
// All pulses and dispense_req are registered one cycle after their cause; empty/busy are decoded.
// No backpressure on inputs: coins are rejected, selects denied, events outside their state ignored.
module vend_controller
  import vend_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_W     = 2,
  parameter int INV_MAX    = 3,
  parameter int PRICE      = 4,
  parameter int MAX_CREDIT = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           coin,
  input  logic                 select_valid,
  input  logic [SLOT_W-1:0]    select_id,
  input  logic                 cancel,
  input  logic                 restock_valid,
  input  logic [SLOT_W-1:0]    restock_id,
  input  logic                 dispense_done,
  output logic [3:0]           credit,
  output logic                 coin_reject,
  output logic                 deny,
  output logic                 dispense_req,
  output logic [SLOT_W-1:0]    dispense_slot,
  output logic                 change_pulse,
  output logic                 fault,
  output logic [NUM_SLOTS-1:0] empty,
  output logic                 busy
);

  localparam int TMO_W = $clog2(TIMEOUT);

  vend_state_t      state;
  logic [TMO_W-1:0] tmo_cnt;

  coin_val_t  coin_info;
  logic [4:0] coin_sum;
  logic       coin_nz;
  logic       coin_ok;
  logic       cancel_ok;
  logic       sel_ok;

  // Decode this cycle's requests against current credit and inventory
  always_comb begin
    coin_info = coin_value(coin);
    coin_nz   = (coin != COIN_NONE);
    coin_sum  = {1'b0, credit} + {2'b00, coin_info.value};
    coin_ok   = coin_info.legal && coin_nz && (coin_sum <= 5'(MAX_CREDIT));
    cancel_ok = (state == S_CREDIT) && cancel;
    sel_ok    = (state == S_CREDIT) && select_valid && !cancel &&
                (credit >= 4'(PRICE)) && !empty[select_id];
  end

  vend_inventory #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W),
    .INV_MAX   (INV_MAX)
  ) u_inv (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (sel_ok),
    .dec_id        (select_id),
    .restock_valid (restock_valid),
    .restock_id    (restock_id),
    .empty         (empty)
  );

  assign busy = (state == S_VEND) || (state == S_CHANGE);

  // Main FSM: credit arithmetic, dispenser handshake, timeout and change payout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      credit        <= '0;
      tmo_cnt       <= '0;
      coin_reject   <= 1'b0;
      deny          <= 1'b0;
      dispense_req  <= 1'b0;
      dispense_slot <= '0;
      change_pulse  <= 1'b0;
      fault         <= 1'b0;
    end else begin
      coin_reject  <= 1'b0;
      deny         <= 1'b0;
      change_pulse <= 1'b0;
      fault        <= 1'b0;
      case (state)
        S_IDLE, S_CREDIT: begin
          if (cancel_ok) begin
            state       <= S_CHANGE;
            coin_reject <= coin_nz;
          end else if (sel_ok) begin
            credit        <= credit - 4'(PRICE);
            dispense_slot <= select_id;
            dispense_req  <= 1'b1;
            tmo_cnt       <= '0;
            state         <= S_VEND;
            coin_reject   <= coin_nz;
          end else begin
            if (select_valid) deny <= 1'b1;
            if (coin_nz) begin
              if (coin_ok) begin
                credit <= 4'(coin_sum);
                state  <= S_CREDIT;
              end else begin
                coin_reject <= 1'b1;
              end
            end
          end
        end
        S_VEND: begin
          coin_reject <= coin_nz;
          if (dispense_done) begin
            dispense_req <= 1'b0;
            tmo_cnt      <= '0;
            state        <= (credit != '0) ? S_CHANGE : S_IDLE;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            // Dispenser never answered: refund the price, item stays consumed
            fault        <= 1'b1;
            credit       <= credit + 4'(PRICE);
            dispense_req <= 1'b0;
            tmo_cnt      <= '0;
            state        <= S_CHANGE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CHANGE: begin
          coin_reject <= coin_nz;
          if (credit != '0) begin
            change_pulse <= 1'b1;
            credit       <= credit - 1'b1;
            if (credit == 4'd1) state <= S_IDLE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Sequencing controller for the vending datapath. Accepts one-hot coin pulses and accumulates credit in quarter units. Arbitrates product selection against per-slot inventory and performs a req/done handshake with the dispenser mechanism. Returns change as one pulse per quarter. Sits between the coin acceptor front end and the dispenser/change hoppers.

Parameters:
NUM_SLOTS, 4, number of product slots
SLOT_W, 2, width of slot index ($clog2(NUM_SLOTS))
INV_MAX, 3, items per slot after reset or restock
PRICE, 4, price of any item in quarters ($1.00)
MAX_CREDIT, 8, credit ceiling in quarters ($2.00)
TIMEOUT, 16, cycles to wait for dispense_done before faulting

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
coin  input  5  one-hot single-cycle coin pulse: bit0 quarter, bit1 fifty, bit2 seventyfive, bit3 dollar, bit4 reserved; 5'b00000 = no coin
select_valid  input  1  single-cycle product request
select_id  input  SLOT_W  requested slot
cancel  input  1  single-cycle refund request
restock_valid  input  1  single-cycle restock strobe
restock_id  input  SLOT_W  slot to refill
dispense_done  input  1  dispenser completion, sampled only in VEND
credit  output  4  current credit in quarters
coin_reject  output  1  one-cycle pulse, coin not accepted
deny  output  1  one-cycle pulse, selection refused
dispense_req  output  1  held high through VEND
dispense_slot  output  SLOT_W  slot being vended, valid while dispense_req
change_pulse  output  1  one pulse per quarter returned
fault  output  1  one-cycle pulse on dispense timeout
empty  output  NUM_SLOTS  bit i set when inventory[i]==0
busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset (async): state IDLE, credit 0, timeout counter 0, every inventory = INV_MAX, all pulse outputs 0, dispense_req 0, dispense_slot 0.
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE. All pulse outputs are registered and assert the cycle after the causing input.
- Coin values: quarter 1, fifty 2, seventyfive 3, dollar 4.
- Coin acceptance in IDLE or CREDIT: a legal coin is added when credit+value <= MAX_CREDIT; otherwise coin_reject fires and credit is unchanged.
- coin with more than one bit set, or bit4 set: coin_reject fires.
- Any nonzero coin in VEND or CHANGE: coin_reject fires.
- First coin accepted in IDLE -> CREDIT.
- Priority within one cycle in IDLE/CREDIT: cancel > select_valid > coin. A coin arriving in the same cycle as an accepted cancel or select is rejected.
- Cancel: in CREDIT -> CHANGE. In IDLE, cancel is ignored.
- Select in CREDIT:
  - Accepted when credit >= PRICE and inventory[select_id] > 0. Then: credit -= PRICE, inventory decrements, dispense_slot <= select_id, dispense_req <= 1, -> VEND.
  - Otherwise deny fires and state is unchanged.
  - Select in IDLE: deny fires.
- VEND:
  - dispense_req stays high; the timeout counter increments every cycle.
  - On dispense_done: dispense_req <= 0, counter cleared, -> CHANGE if credit>0, else IDLE.
  - If the counter reaches TIMEOUT-1 without dispense_done: fault fires, credit += PRICE (refund), inventory is not restored, dispense_req drops, -> CHANGE.
- CHANGE: each cycle, change_pulse is high for one cycle and credit decrements by 1. After the pulse that brings credit to 0 -> IDLE. Credit N yields exactly N consecutive pulses. Selects and cancels are ignored.
- Restock: accepted in any state and sets inventory[restock_id] = INV_MAX. If it coincides with a decrement of the same slot, restock wins.
- empty and busy are decoded combinationally from registered state; credit is driven directly from its register.
- Reset asserted mid-VEND or mid-CHANGE: credit is discarded, outputs go to their reset values immediately, and no change is paid.

Decomposition:
- Package vend_pkg: coin encoding constants (COIN_NONE, COIN_QUARTER, COIN_FIFTY, COIN_SEVENTYFIVE, COIN_DOLLAR), state enum vend_state_t, function coin_value() returning 0..4 plus a legality flag.
- One sub-module, vend_inventory: NUM_SLOTS counters with decrement/restock ports and the empty vector. The FSM and credit arithmetic stay in vend_controller.

Test Plan:
1. Coins quarter, fifty, fifty (one cycle apart) -> credit 1, 3, 5. Select slot 0 -> dispense_req=1, dispense_slot=0, credit=1. dispense_done after 3 cycles -> one change_pulse, then IDLE with credit 0. Inventory slot 0 becomes 2.
2. Coin quarter then select slot 1 -> deny pulse, credit stays 1. Then cancel -> one change_pulse, credit 0, IDLE.
3. Two dollars then a quarter -> credit 8, coin_reject on the quarter. Illegal coin 5'b00011 -> coin_reject, credit unchanged.
4. Credit 4, select slot 2, dispense_done never asserted -> fault pulse on the 16th VEND cycle, then 4 change_pulses, IDLE, inventory slot 2 = 2.
5. Three vends of slot 3 -> empty[3]=1. Fourth select -> deny. restock_valid slot 3 -> empty[3]=0, next select succeeds.
6. Coin during VEND -> coin_reject. Reset asserted during CHANGE with credit 3 -> credit 0, change_pulse 0, state IDLE, no further pulses after release.
